// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte producers.
// Latches the granted byte, holds tx_start until tx_busy, waits for frame end.
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int START_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     ack,
  output logic                   done,
  output logic                   err,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  input  logic                   tx_busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(START_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [PW:0]   NREQ     = (PW+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    START,
    BUSY
  } state_e;

  state_e               state_q;
  logic [PW-1:0]        ptr_q;
  logic [PW-1:0]        gidx_q;
  logic [CW-1:0]        cnt_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 done_q;
  logic                 err_q;
  logic                 tx_start_q;
  logic [7:0]           tx_data_q;

  logic [7:0]           lane [NUM_REQ];
  logic                 sel_vld_d;
  logic [PW-1:0]        sel_idx_d;
  logic [PW:0]          sum;
  logic [PW:0]          nxt;
  logic [PW-1:0]        ptr_inc_d;

  assign grant    = grant_q;
  assign ack      = ack_q;
  assign done     = done_q;
  assign err      = err_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      lane[i] = req_data[8*i +: 8];
    end
  end

  // Scan from the highest offset down so the nearest set bit to ptr wins.
  always_comb begin
    sel_vld_d = 1'b0;
    sel_idx_d = '0;
    sum       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (sum >= NREQ) begin
        sum = sum - NREQ;
      end
      if (req[sum[PW-1:0]]) begin
        sel_vld_d = 1'b1;
        sel_idx_d = sum[PW-1:0];
      end
    end
  end

  always_comb begin
    nxt = {1'b0, gidx_q} + (PW+1)'(1);
    if (nxt >= NREQ) begin
      nxt = '0;
    end
    ptr_inc_d = nxt[PW-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gidx_q     <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      ack_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      ack_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!tx_busy && sel_vld_d) begin
            grant_q    <= NUM_REQ'(1) << sel_idx_d;
            gidx_q     <= sel_idx_d;
            tx_data_q  <= lane[sel_idx_d];
            tx_start_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= START;
          end
        end
        START: begin
          if (tx_busy) begin
            ack_q      <= grant_q;
            tx_start_q <= 1'b0;
            state_q    <= BUSY;
          end else if (cnt_q == CNT_LAST) begin
            tx_start_q <= 1'b0;
            grant_q    <= '0;
            err_q      <= 1'b1;
            ptr_q      <= ptr_inc_d;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BUSY: begin
          if (!tx_busy) begin
            done_q  <= 1'b1;
            grant_q <= '0;
            ptr_q   <= ptr_inc_d;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
